// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// The FSM encoding is fixed so that state values stay stable across revisions.
package mem_stage_pkg;

  localparam int unsigned DATA_W           = 16;
  localparam int unsigned MAX_WAIT_DEFAULT = 15;
  localparam int unsigned ADDR_W_DEFAULT   = 16;
  localparam int unsigned WAIT_CNT_W       = 8;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  // Request captured at issue and held for the whole access
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic is_mem_op(input logic re, input logic we);
    return re | we;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts ACCESS cycles spent waiting for an acknowledge.
// o_expired_c flags the MAX_WAIT-th enabled cycle, so the caller can give up on it.
module mem_wait_timer
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] r_count;

  // Saturates at LAST so a held enable cannot wrap back to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + WAIT_CNT_W'(1);
    end
  end

  assign o_expired_c = i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack handshake, stalls the core
// while the access is in flight and passes non-memory results straight through.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_re,
  input  logic              mem_we,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack
);

  state_e            r_state;
  state_e            w_next;
  mem_req_t          r_req;
  logic              r_dm_req;
  logic              r_dm_we;
  logic              r_err;
  logic [DATA_W-1:0] r_rd;

  logic w_start;
  logic w_conflict;
  logic w_ack;
  logic w_expired;
  logic w_leave;
  logic w_tmr_clear;
  logic w_tmr_en;

  assign w_start    = (r_state == IDLE) && is_mem_op(mem_re, mem_we);
  assign w_conflict = (r_state == IDLE) && mem_re && mem_we;
  assign w_ack      = (r_state == ACCESS) && dm_ack;
  assign w_leave    = w_ack || w_expired;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_tmr_clear),
    .i_enable    (w_tmr_en),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DONE always returns to IDLE so the retiring instruction's enables cannot re-issue
  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    wb_data     = alu_result;
    w_tmr_clear = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          stall       = 1'b1;
          w_tmr_clear = 1'b1;
          w_next      = ACCESS;
        end
      end
      ACCESS: begin
        stall    = 1'b1;
        w_tmr_en = !dm_ack;
        if (dm_ack || w_expired) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
        if (!r_req.we) begin
          wb_data = r_rd;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request, handshake and load-data registers; an ack in the last allowed cycle beats timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req    <= '0;
      r_dm_req <= 1'b0;
      r_dm_we  <= 1'b0;
      r_rd     <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_start) begin
        r_req    <= '{we: mem_we, addr: alu_result, wdata: store_data};
        r_dm_req <= 1'b1;
        r_dm_we  <= mem_we;
      end
      if (w_conflict) begin
        r_err <= 1'b1;
      end
      if (w_leave) begin
        r_dm_req <= 1'b0;
        r_dm_we  <= 1'b0;
      end
      if (w_ack && !r_req.we) begin
        r_rd <= dm_rdata;
      end else if (w_expired) begin
        r_rd  <= TIMEOUT_DATA;
        r_err <= 1'b1;
      end
    end
  end

  assign dm_req   = r_dm_req;
  assign dm_we    = r_dm_we;
  assign dm_addr  = ADDR_W'(r_req.addr);
  assign dm_wdata = r_req.wdata;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a short (MAX_WAIT=4) timeout.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic        mem_re;
  logic        mem_we;
  logic        stall;
  logic [15:0] wb_data;
  logic        err;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_ack;

  int checks = 0;
  int errors = 0;

  mem_stage #(
    .MAX_WAIT (4),
    .ADDR_W   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .stall      (stall),
    .wb_data    (wb_data),
    .err        (err),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ack     (dm_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; alu_result = 16'h5A5A; store_data = 16'h0; mem_re = 1'b0; mem_we = 1'b0;
    dm_ack = 1'b0; dm_rdata = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (wb_data !== 16'h5A5A) begin errors++; $display("FAIL reset_wb: got %h expected 5a5a", wb_data); end
    checks++; if (dm_req !== 1'b0 || dm_we !== 1'b0) begin errors++; $display("FAIL reset_req: got req=%b we=%b expected 0 0", dm_req, dm_we); end
    checks++; if (dm_addr !== 16'h0 || dm_wdata !== 16'h0) begin errors++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0 0", dm_addr, dm_wdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_non_mem();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); alu_result = 16'h1234 + 16'(i); mem_re = 1'b0; mem_we = 1'b0; #1;
      checks++;
      if (wb_data !== 16'h1234 + 16'(i) || stall !== 1'b0 || dm_req !== 1'b0) begin
        errors++; $display("FAIL non_mem[%0d]: got wb=%h stall=%b req=%b expected wb=%h stall=0 req=0",
                           i, wb_data, stall, dm_req, 16'h1234 + 16'(i));
      end
    end
  endtask

  task automatic test_load_wait();
    int stall_cycles = 0;
    @(negedge clk); alu_result = 16'h0040; mem_re = 1'b1; mem_we = 1'b0; dm_ack = 1'b0; dm_rdata = 16'hDEAD; #1;
    if (stall === 1'b1) stall_cycles++;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL load_issue_req: got %b expected 0", dm_req); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); dm_ack = (i == 4); dm_rdata = (i == 4) ? 16'hBEEF : 16'hDEAD; #1;
      if (stall === 1'b1) stall_cycles++;
      checks++;
      if (dm_req !== 1'b1 || dm_addr !== 16'h0040 || dm_we !== 1'b0) begin
        errors++; $display("FAIL load_access[%0d]: got req=%b addr=%h we=%b expected 1 0040 0", i, dm_req, dm_addr, dm_we);
      end
    end
    @(negedge clk); dm_ack = 1'b0; dm_rdata = 16'hDEAD; #1;
    if (stall === 1'b1) stall_cycles++;
    checks++; if (wb_data !== 16'hBEEF) begin errors++; $display("FAIL load_wb: got %h expected beef", wb_data); end
    checks++; if (dm_req !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL load_done: got req=%b err=%b expected 0 0", dm_req, err); end
    checks++; if (stall_cycles != 5) begin errors++; $display("FAIL load_stall_len: got %0d expected 5", stall_cycles); end
    @(negedge clk); mem_re = 1'b0; alu_result = 16'h7777; #1;
    checks++;
    if (wb_data !== 16'h7777 || stall !== 1'b0 || dm_req !== 1'b0) begin
      errors++; $display("FAIL load_after: got wb=%h stall=%b req=%b expected 7777 0 0", wb_data, stall, dm_req);
    end
  endtask

  task automatic test_store_immediate();
    @(negedge clk); alu_result = 16'h0010; store_data = 16'hA5A5; mem_we = 1'b1; mem_re = 1'b0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_issue_stall: got %b expected 1", stall); end
    @(negedge clk); dm_ack = 1'b1; #1;
    checks++;
    if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wdata !== 16'hA5A5 || dm_addr !== 16'h0010 || stall !== 1'b1) begin
      errors++; $display("FAIL store_access: got req=%b we=%b wdata=%h addr=%h stall=%b expected 1 1 a5a5 0010 1",
                         dm_req, dm_we, dm_wdata, dm_addr, stall);
    end
    @(negedge clk); dm_ack = 1'b0; #1;
    checks++;
    if (stall !== 1'b0 || dm_req !== 1'b0 || dm_we !== 1'b0 || wb_data !== 16'h0010) begin
      errors++; $display("FAIL store_done: got stall=%b req=%b we=%b wb=%h expected 0 0 0 0010", stall, dm_req, dm_we, wb_data);
    end
    @(negedge clk); mem_we = 1'b0; alu_result = 16'h0003; #1;
    checks++;
    if (dm_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL store_no_retrigger: got req=%b stall=%b err=%b expected 0 0 0", dm_req, stall, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [2];
    logic [15:0] datas [2];
    addrs[0] = 16'h0100; datas[0] = 16'h1111;
    addrs[1] = 16'h0102; datas[1] = 16'h2222;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); alu_result = addrs[k]; mem_re = 1'b1; mem_we = 1'b0; dm_ack = 1'b0; #1;
      checks++; if (stall !== 1'b1 || dm_req !== 1'b0) begin errors++; $display("FAIL b2b_issue[%0d]: got stall=%b req=%b expected 1 0", k, stall, dm_req); end
      @(negedge clk); dm_ack = 1'b1; dm_rdata = datas[k]; #1;
      checks++; if (dm_addr !== addrs[k] || dm_req !== 1'b1) begin errors++; $display("FAIL b2b_access[%0d]: got addr=%h req=%b expected %h 1", k, dm_addr, dm_req, addrs[k]); end
      @(negedge clk); dm_ack = 1'b0; dm_rdata = 16'h0; #1;
      checks++; if (wb_data !== datas[k] || stall !== 1'b0) begin errors++; $display("FAIL b2b_wb[%0d]: got wb=%h stall=%b expected %h 0", k, wb_data, stall, datas[k]); end
    end
    mem_re = 1'b0;
  endtask

  task automatic test_ack_outside();
    @(negedge clk); alu_result = 16'h0ABC; mem_re = 1'b0; mem_we = 1'b0; dm_ack = 1'b1; dm_rdata = 16'hFFFF; #1;
    checks++;
    if (dm_req !== 1'b0 || stall !== 1'b0 || wb_data !== 16'h0ABC) begin
      errors++; $display("FAIL stray_ack_idle: got req=%b stall=%b wb=%h expected 0 0 0abc", dm_req, stall, wb_data);
    end
    @(negedge clk); dm_ack = 1'b0; #1;
    checks++; if (dm_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL stray_ack_after: got req=%b stall=%b expected 0 0", dm_req, stall); end
  endtask

  task automatic test_ack_at_limit();
    @(negedge clk); alu_result = 16'h0030; store_data = 16'h0F0F; mem_we = 1'b1; mem_re = 1'b0; dm_ack = 1'b0; #1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); dm_ack = (i == 4); #1;
      checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL limit_access[%0d]: got req=%b expected 1", i, dm_req); end
    end
    @(negedge clk); dm_ack = 1'b0; #1;
    checks++;
    if (err !== 1'b0 || wb_data !== 16'h0030 || dm_req !== 1'b0) begin
      errors++; $display("FAIL limit_done: got err=%b wb=%h req=%b expected 0 0030 0", err, wb_data, dm_req);
    end
    @(negedge clk); mem_we = 1'b0; #1;
  endtask

  task automatic test_timeout();
    @(negedge clk); alu_result = 16'h0080; mem_re = 1'b1; mem_we = 1'b0; dm_ack = 1'b0; #1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      checks++; if (dm_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL timeout_access[%0d]: got req=%b stall=%b expected 1 1", i, dm_req, stall); end
    end
    @(negedge clk); dm_ack = 1'b1; dm_rdata = 16'h9999; #1;
    checks++;
    if (dm_req !== 1'b0 || err !== 1'b1 || wb_data !== 16'h0000 || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_done: got req=%b err=%b wb=%h stall=%b expected 0 1 0000 0", dm_req, err, wb_data, stall);
    end
    @(negedge clk); mem_re = 1'b0; dm_ack = 1'b0; alu_result = 16'h4242; #1;
    checks++;
    if (wb_data !== 16'h4242 || stall !== 1'b0 || dm_req !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL timeout_after: got wb=%h stall=%b req=%b err=%b expected 4242 0 0 1", wb_data, stall, dm_req, err);
    end
  endtask

  task automatic test_conflict();
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b expected 0", err); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); alu_result = 16'h0050; store_data = 16'h3C3C; mem_re = 1'b1; mem_we = 1'b1; #1;
    checks++; if (stall !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL conflict_issue: got stall=%b err=%b expected 1 0", stall, err); end
    @(negedge clk); dm_ack = 1'b1; #1;
    checks++;
    if (dm_we !== 1'b1 || dm_wdata !== 16'h3C3C || dm_addr !== 16'h0050 || err !== 1'b1) begin
      errors++; $display("FAIL conflict_access: got we=%b wdata=%h addr=%h err=%b expected 1 3c3c 0050 1", dm_we, dm_wdata, dm_addr, err);
    end
    @(negedge clk); dm_ack = 1'b0; dm_rdata = 16'hEEEE; #1;
    checks++; if (wb_data !== 16'h0050 || err !== 1'b1) begin errors++; $display("FAIL conflict_done: got wb=%h err=%b expected 0050 1", wb_data, err); end
    @(negedge clk); mem_re = 1'b0; mem_we = 1'b0; #1;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk); alu_result = 16'h0060; mem_re = 1'b1; mem_we = 1'b0; dm_ack = 1'b0; #1;
    @(negedge clk); #1;
    checks++; if (dm_req !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL midrst_before: got req=%b err=%b expected 1 1", dm_req, err); end
    #2; rst = 1'b1; #1;
    checks++;
    if (dm_req !== 1'b0 || err !== 1'b0 || dm_addr !== 16'h0 || dm_we !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got req=%b err=%b addr=%h we=%b expected 0 0 0000 0", dm_req, err, dm_addr, dm_we);
    end
    @(negedge clk); rst = 1'b0; mem_re = 1'b0; alu_result = 16'h1111; #1;
    checks++;
    if (stall !== 1'b0 || wb_data !== 16'h1111 || dm_req !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midrst_after: got stall=%b wb=%h req=%b err=%b expected 0 1111 0 0", stall, wb_data, dm_req, err);
    end
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_load_wait();
    test_store_immediate();
    test_back_to_back();
    test_ack_outside();
    test_ack_at_limit();
    test_timeout();
    test_conflict();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage sitting directly downstream of the 16-bit ALU. It takes the ALU result as a data-memory address (or as pass-through writeback data), performs loads/stores to a data memory with variable latency over a req/ack handshake, and stalls the rest of the core until the access completes. Non-memory instructions pass through with no added latency; a bounded wait counter flags a memory that never acknowledges.

## Interface

- MAX_WAIT, 15: maximum ACCESS cycles without dm_ack before timeout (1..255)
- ADDR_W, 16: data-memory address width (low ADDR_W bits of alu_result)

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_result  in  16  ALU dst; address for loads/stores, writeback data otherwise
- store_data  in  16  register-file value to store
- mem_re  in  1  current instruction is a load
- mem_we  in  1  current instruction is a store
- stall  out  1  freeze PC/register-file write while high
- wb_data  out  16  writeback value (load data or alu_result)
- err  out  1  sticky: timeout or re/we conflict seen
- dm_req  out  1  memory request, held until dm_ack
- dm_we  out  1  write enable, valid with dm_req
- dm_addr  out  ADDR_W  address, valid with dm_req
- dm_wdata  out  16  store data, valid with dm_req
- dm_rdata  in  16  load data, valid when dm_ack
- dm_ack  in  1  single-cycle completion pulse

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE: if mem_re|mem_we, stall=1 combinationally; latch address, store_data, write flag into request registers; clear wait counter; go ACCESS. Else stall=0, wb_data=alu_result.
- ACCESS: dm_req=1, dm_we/dm_addr/dm_wdata driven from request registers (stable for whole access); stall=1. On dm_ack: capture dm_rdata into rd_reg (loads only), go DONE. Else increment counter; when counter reaches MAX_WAIT with no ack: err<=1, rd_reg<=16'h0000, go DONE.
- DONE: stall=0, dm_req=0; wb_data=rd_reg for loads, alu_result for stores; instruction retires on this edge; go IDLE unconditionally (the still-asserted mem_re/mem_we of the retiring instruction must not re-trigger).
- mem_re and mem_we both high: treat as store, set err.
- err cleared only by rst.

## Timing

- Reset values: state IDLE, dm_req 0, dm_we 0, dm_addr 0, dm_wdata 0, rd_reg 0, counter 0, err 0; stall 0 and wb_data=alu_result as combinational consequences of IDLE.
- rst asserted mid-access: dm_req drops immediately (asynchronous), no data captured, no err.
- Load/store with ack in first ACCESS cycle: 3 cycles total (IDLE, ACCESS, DONE), stall high for 2. Each extra wait cycle adds 1.
- dm_ack on same cycle counter hits MAX_WAIT: ack wins, no err.
- dm_ack outside ACCESS: ignored.
- Non-memory instruction: zero latency, stall never asserted.

## Structure

- Shared package mem_stage_pkg: state enum (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10), MAX_WAIT default, timeout data constant 16'h0000.
- One sub-module: mem_wait_timer (clear, enable, count, expired at MAX_WAIT), instantiated once.
- Request registers, rd_reg and writeback mux in the top module.

## Test plan

- Non-memory: alu_result=16'h1234, mem_re=mem_we=0 -> wb_data=16'h1234, stall 0, dm_req never asserted.
- Load, ack after 3 waits: alu_result=16'h0040, dm_rdata=16'hBEEF -> dm_addr=16'h0040 held 4 cycles, stall high 5 cycles, wb_data=16'hBEEF in DONE, err 0.
- Store, immediate ack: alu_result=16'h0010, store_data=16'hA5A5 -> dm_we=1, dm_wdata=16'hA5A5 for 1 cycle, stall high 2 cycles, no re-trigger in DONE.
- Timeout: MAX_WAIT=4, no ack -> dm_req high 4 cycles, err=1, wb_data=16'h0000, then IDLE; ack on 4th cycle instead -> err stays 0.
- Conflict and reset: mem_re=mem_we=1 -> store issued, err=1; rst mid-ACCESS -> dm_req 0 same cycle, state IDLE, err 0.
